serial_sub_ctrl: RTL and testbench

//  Bit-serial unsigned subtractor controller: computes A-B for WIDTH-bit operands, LSB first,

---
 rtl/serial_sub_ctrl_pkg.sv | 18 +
 rtl/serial_sub_ctrl_if.sv | 24 ++
 rtl/serial_sub_ctrl_cell.sv | 29 ++
 rtl/serial_sub_ctrl_half_sub.sv | 10 +
 rtl/serial_sub_ctrl.sv | 100 ++++++++++
 tb/tb_serial_sub_ctrl.sv | 206 ++++++++++++++++++++
 6 files changed

// File: rtl/serial_sub_ctrl_pkg.sv
// rtl/serial_sub_ctrl_pkg.sv - shared state encoding and sizing helpers for the serial subtractor
package serial_sub_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 64;

    // A 1-bit operand still needs a 1-bit counter so the RUN compare stays well formed.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_sub_ctrl_if.sv
// rtl/serial_sub_ctrl_if.sv - operand/result handshake bundle for the serial subtractor
interface serial_sub_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow, busy
    );
endinterface

// File: rtl/serial_sub_ctrl_cell.sv
// rtl/serial_sub_ctrl_cell.sv - 1-bit full subtract cell from two half subtractors
module full_sub_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);
    logic d1;
    logic b1;
    logic b2;

    half_subtractor u_hs_ab (
        .a_i    (a_i),
        .b_i    (b_i),
        .d_o    (d1),
        .bout_o (b1)
    );

    // Second stage subtracts the incoming borrow from the partial difference.
    half_subtractor u_hs_bin (
        .a_i    (d1),
        .b_i    (bin_i),
        .d_o    (d_o),
        .bout_o (b2)
    );

    assign bout_o = b1 | b2;
endmodule

// File: rtl/serial_sub_ctrl_half_sub.sv
// rtl/serial_sub_ctrl_half_sub.sv - 1-bit half subtractor
module half_subtractor (
    input  logic a_i,
    input  logic b_i,
    output logic d_o,
    output logic bout_o
);
    assign d_o    = a_i ^ b_i;
    assign bout_o = ~a_i & b_i;
endmodule

// File: rtl/serial_sub_ctrl.sv
// rtl/serial_sub_ctrl.sv - bit-serial unsigned A-B controller, LSB first, one cell per cycle
module serial_sub_ctrl
    import serial_sub_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic               clk,
    input logic               rst_n,
    serial_sub_ctrl_if.slave  bus
);
    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] diff_q;
    logic [WIDTH-1:0] diff_d;
    logic [CW-1:0]    cnt_q;
    logic             brw_q;
    logic             out_valid_q;
    logic             busy_q;
    logic             cell_d;
    logic             cell_bo;
    logic             last_bit;

    full_sub_cell u_cell (
        .a_i    (a_sh_q[0]),
        .b_i    (b_sh_q[0]),
        .bin_i  (brw_q),
        .d_o    (cell_d),
        .bout_o (cell_bo)
    );

    // Difference bits enter at the top and walk down, so the LSB lands at bit 0 last.
    generate
        if (WIDTH == 1) begin : g_diff_w1
            assign diff_d = cell_d;
        end else begin : g_diff_wn
            assign diff_d = {cell_d, diff_q[WIDTH-1:1]};
        end
    endgenerate

    assign last_bit = (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            diff_q      <= '0;
            cnt_q       <= '0;
            brw_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        a_sh_q  <= bus.a;
                        b_sh_q  <= bus.b;
                        brw_q   <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    diff_q <= diff_d;
                    a_sh_q <= a_sh_q >> 1;
                    b_sh_q <= b_sh_q >> 1;
                    brw_q  <= cell_bo;
                    cnt_q  <= cnt_q + 1'b1;
                    if (last_bit) begin
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.diff      = diff_q;
    assign bus.borrow    = brw_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb/tb_serial_sub_ctrl.sv - directed self-checking bench for serial_sub_ctrl (WIDTH 8 and 1)
module tb_serial_sub_ctrl;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    serial_sub_ctrl_if #(.WIDTH(8)) bus8 ();
    serial_sub_ctrl_if #(.WIDTH(1)) bus1 ();

    serial_sub_ctrl #(.WIDTH(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    serial_sub_ctrl #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready8(input string tag);
        int w;
        w = 0;
        while (!bus8.in_ready && w < 40) begin
            tick();
            w++;
        end
        check({tag, "_in_ready"}, bus8.in_ready, 1);
    endtask

    task automatic wait_result8(input string tag, input logic [7:0] ed, input logic eb);
        int lat;
        lat = 0;
        while (!bus8.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, 8);
        check({tag, "_diff"}, bus8.diff, ed);
        check({tag, "_borrow"}, bus8.borrow, eb);
    endtask

    task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                          input logic [7:0] ed, input logic eb, input string tag);
        wait_ready8(tag);
        bus8.a         = av;
        bus8.b         = bv;
        bus8.in_valid  = 1'b1;
        bus8.out_ready = 1'b1;
        tick();
        bus8.in_valid = 1'b0;
        check({tag, "_busy"}, bus8.busy, 1);
        wait_result8(tag, ed, eb);
        tick();
        check({tag, "_ov_clear"}, bus8.out_valid, 0);
        check({tag, "_idle"}, bus8.in_ready, 1);
    endtask

    logic [7:0] bb_a  [3];
    logic [7:0] bb_b  [3];
    logic [7:0] bb_d  [3];
    logic       bb_br [3];
    logic       w1_d  [4];
    logic       w1_br [4];

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n          = 1'b0;
        bus8.in_valid  = 1'b0;
        bus8.a         = '0;
        bus8.b         = '0;
        bus8.out_ready = 1'b0;
        bus1.in_valid  = 1'b0;
        bus1.a         = '0;
        bus1.b         = '0;
        bus1.out_ready = 1'b0;

        bb_a[0] = 8'h10; bb_b[0] = 8'h01; bb_d[0] = 8'h0F; bb_br[0] = 1'b0;
        bb_a[1] = 8'h01; bb_b[1] = 8'h02; bb_d[1] = 8'hFF; bb_br[1] = 1'b1;
        bb_a[2] = 8'hC8; bb_b[2] = 8'h64; bb_d[2] = 8'h64; bb_br[2] = 1'b0;
        // index = {a,b}
        w1_d[0] = 1'b0; w1_br[0] = 1'b0;
        w1_d[1] = 1'b1; w1_br[1] = 1'b1;
        w1_d[2] = 1'b1; w1_br[2] = 1'b0;
        w1_d[3] = 1'b0; w1_br[3] = 1'b0;

        repeat (3) tick();
        rst_n = 1'b1;
        check("rst_in_ready", bus8.in_ready, 1);
        check("rst_out_valid", bus8.out_valid, 0);
        check("rst_diff", bus8.diff, 0);
        check("rst_borrow", bus8.borrow, 0);
        check("rst_busy", bus8.busy, 0);

        run_op(8'h5A, 8'h3C, 8'h1E, 1'b0, "op_5a_3c");
        run_op(8'h00, 8'h01, 8'hFF, 1'b1, "op_00_01");
        run_op(8'hFF, 8'hFF, 8'h00, 1'b0, "op_ff_ff");

        // Backpressure with stray operand pulses while the result is held.
        wait_ready8("bp");
        bus8.a = 8'h12; bus8.b = 8'h34; bus8.in_valid = 1'b1; bus8.out_ready = 1'b0;
        tick();
        bus8.in_valid = 1'b0;
        wait_result8("bp", 8'hDE, 1'b1);
        for (int i = 0; i < 5; i++) begin
            bus8.in_valid = (i % 2 == 0);
            bus8.a = 8'hAA;
            bus8.b = 8'h01;
            tick();
            check("bp_hold_valid", bus8.out_valid, 1);
            check("bp_hold_diff", bus8.diff, 8'hDE);
            check("bp_hold_borrow", bus8.borrow, 1);
            check("bp_hold_in_ready", bus8.in_ready, 0);
        end
        bus8.in_valid  = 1'b0;
        bus8.out_ready = 1'b1;
        tick();
        check("bp_release_ov", bus8.out_valid, 0);
        check("bp_release_ready", bus8.in_ready, 1);
        tick();
        check("bp_no_ghost_busy", bus8.busy, 0);

        // Reset on the fourth RUN cycle.
        wait_ready8("mr");
        bus8.a = 8'h33; bus8.b = 8'h11; bus8.in_valid = 1'b1;
        tick();
        bus8.in_valid = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mr_in_ready", bus8.in_ready, 1);
        check("mr_out_valid", bus8.out_valid, 0);
        check("mr_diff", bus8.diff, 0);
        check("mr_busy", bus8.busy, 0);
        run_op(8'h80, 8'h7F, 8'h01, 1'b0, "op_80_7f");

        // Back-to-back with in_valid held high.
        bus8.out_ready = 1'b1;
        bus8.a = bb_a[0]; bus8.b = bb_b[0]; bus8.in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_ready8("b2b");
            tick();
            check("b2b_accept_busy", bus8.busy, 1);
            if (k < 2) begin
                bus8.a = bb_a[k+1];
                bus8.b = bb_b[k+1];
            end
            wait_result8("b2b", bb_d[k], bb_br[k]);
            if (k == 2) bus8.in_valid = 1'b0;
            tick();
            check("b2b_idle_after_hs", bus8.in_ready, 1);
        end
        tick();
        check("b2b_no_extra_op", bus8.busy, 0);
        check("b2b_no_extra_ov", bus8.out_valid, 0);

        // WIDTH=1 instance, all operand combinations.
        bus1.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] ab;
            ab = 2'(i);
            bus1.a = ab[1];
            bus1.b = ab[0];
            bus1.in_valid = 1'b1;
            check("w1_in_ready", bus1.in_ready, 1);
            tick();
            bus1.in_valid = 1'b0;
            check("w1_run_ov", bus1.out_valid, 0);
            tick();
            check("w1_out_valid", bus1.out_valid, 1);
            check("w1_diff", bus1.diff, w1_d[i]);
            check("w1_borrow", bus1.borrow, w1_br[i]);
            tick();
            check("w1_ov_clear", bus1.out_valid, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
